// File: rtl/apb_mem_slave.sv
// APB4 memory-backed completer: DEPTH-word register file with byte strobes,
// fixed access wait states and PSLVERR for addresses beyond the array.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NB);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]     WS_L    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    pready_q, pready_d;
  logic                    err_p1;
  logic [DATA_WIDTH-1:0]   prdata_q;

  logic [MEM_AW-1:0]       idx_p1;
  logic                    write_p1;
  logic [DATA_WIDTH-1:0]   wdata_p1;
  logic [NB-1:0]           strb_p1;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]        idx;
  logic                    in_range;
  logic                    setup;
  logic                    complete;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

  assign idx      = PADDR[ADDR_WIDTH-1:LSB];
  assign in_range = ({1'b0, idx} < DEPTH_L);
  assign setup    = (state_q == IDLE) && PSEL && !PENABLE;
  assign complete = (state_q == ACCESS) && PSEL && PENABLE && pready_q;
  assign rd_word  = in_range ? mem[idx[MEM_AW-1:0]] : '0;

  generate
    if (LSB > 0) begin : g_addr_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^PADDR[LSB-1:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = pready_q;
    case (state_q)
      IDLE: begin
        pready_d = 1'b0;
        if (setup) begin
          state_d  = ACCESS;
          cnt_d    = WS_L;
          pready_d = (WS_L == 4'd0);
        end
      end
      ACCESS: begin
        // Completion and abort both end the transfer; only completion writes.
        if (!(PSEL && PENABLE) || pready_q) begin
          state_d  = IDLE;
          cnt_d    = 4'd0;
          pready_d = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_d    = cnt_q - 4'd1;
          pready_d = (cnt_q == 4'd1);
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 4'd0;
        pready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      pready_q <= 1'b0;
      err_p1   <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      if (setup) begin
        err_p1 <= !in_range;
        if (!PWRITE) prdata_q <= rd_word;
      end
    end
  end

  // Stage 1: transfer attributes captured at the setup edge.
  always_ff @(posedge PCLK) begin
    if (setup) begin
      idx_p1   <= idx[MEM_AW-1:0];
      write_p1 <= PWRITE;
      wdata_p1 <= PWDATA;
      strb_p1  <= PSTRB;
    end
    if (!PRESET && complete && write_p1 && !err_p1) begin
      mem[idx_p1] <= merge_lanes(mem[idx_p1], wdata_p1, strb_p1);
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pready_q & err_p1;

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-backed completer: a word-organised register file of DEPTH entries with byte-lane write strobes, configurable access wait states, and PSLVERR for out-of-range addresses. It sits behind the APB bridge/decoder as a generic scratch/config memory. It supersedes the fixed 8-bit, zero-wait slave: PREADY and PRDATA are registered, and every transfer follows the APB4 setup/access handshake.

## Interface
- ADDR_WIDTH, 10: PADDR width in bits (byte address).
- DATA_WIDTH, 32: data bus width; must be 8, 16 or 32.
- DEPTH, 64: number of DATA_WIDTH words; must be ≤ 2^(ADDR_WIDTH−log2(DATA_WIDTH/8)).
- WAIT_STATES, 0: PREADY-low cycles inserted in every access phase (0..15).
- PCLK in 1: clock; all logic on rising edge.
- PRESET in 1: reset, synchronous, active-high.
- PSEL in 1: slave select.
- PENABLE in 1: access phase indicator.
- PWRITE in 1: 1 = write, 0 = read.
- PADDR in ADDR_WIDTH: byte address.
- PWDATA in DATA_WIDTH: write data.
- PSTRB in DATA_WIDTH/8: write byte-lane enables.
- PRDATA out DATA_WIDTH: registered read data.
- PREADY out 1: transfer completion.
- PSLVERR out 1: error response, meaningful only while PREADY = 1.

## Operation
- Word index: idx = PADDR[ADDR_WIDTH−1 : log2(DATA_WIDTH/8)].
- Low address bits are ignored, so unaligned addresses map to the containing word.
- Out of range: idx ≥ DEPTH.
- The FSM has two states, IDLE and ACCESS, plus a 4-bit wait counter `cnt`.
- IDLE → ACCESS on PSEL & !PENABLE (setup phase). At that edge:
  - latch idx, PWRITE, PWDATA, PSTRB and `err` = (idx ≥ DEPTH);
  - load `cnt` = WAIT_STATES;
  - for a read, load PRDATA ← mem[idx], or 0 if out of range; for a write, PRDATA holds.
- ACCESS:
  - PREADY = (cnt == 0), registered;
  - `cnt` decrements each cycle while nonzero.
- Completion: the cycle where PSEL & PENABLE & PREADY are all 1. At that edge:
  - an in-range write updates each byte lane k where PSTRB[k] = 1; other lanes are unchanged;
  - an out-of-range write is dropped;
  - the FSM returns to IDLE.
- PSLVERR = PREADY & `err`.
- A read with PSTRB ≠ 0 is legal, and PSTRB is ignored.
- PSTRB = 0 on a write completes normally with no memory change.
- Abort: if PSEL or PENABLE falls in ACCESS before completion, return to IDLE with no write. The abort does not report an error.
- PENABLE high in IDLE without a preceding setup is ignored and stays in IDLE.
- The memory array is not cleared by reset; contents are undefined until written.

## Timing
- Reset values: PREADY = 0, PSLVERR = 0, PRDATA = 0, state = IDLE, `cnt` = 0.
- Reset has priority over every other event. Reset during ACCESS drops the pending write.
- Latency from setup edge to completion is WAIT_STATES + 1 access cycles.
  - WAIT_STATES = 0: PREADY is high in the first access cycle, so a transfer takes 2 PCLK cycles.
- PRDATA is stable from the first access cycle until the next read setup.
- Back-to-back transfers: a setup may occur in the cycle after completion. There is no idle cycle needed between transfers.
- Read-after-write to the same idx sees the new data, because the write commits at the completion edge, which precedes the next setup edge.
- PREADY drops to 0 in the cycle after completion.

## Test plan
- Reset, then idle: PREADY, PSLVERR and PRDATA are 0. Assert PRESET mid-ACCESS of a write to 0x010 with WAIT_STATES = 3; after reset, a read of 0x010 returns a non-written value and PREADY was never seen.
- WAIT_STATES = 0: write 0xDEADBEEF to 0x004 with PSTRB = 0xF, then read 0x004. Each transfer takes 2 cycles, PRDATA = 0xDEADBEEF, PSLVERR = 0.
- Strobes: write 0x11223344 to 0x008 with PSTRB = 0xF, then write 0xAABBCCDD with PSTRB = 0x5. A read returns 0x11BB33DD.
- WAIT_STATES = 3: PREADY is low for exactly 3 access cycles and high on the 4th. Completion occurs in cycle 5 after setup.
- Out of range: write to 0x100 (idx 64) raises PSLVERR = 1 with PREADY, and a read of 0x000 is unchanged. A read of 0x3FC returns PRDATA = 0 with PSLVERR = 1.
- Back-to-back and abort:
  - write 0x5 then immediately read 0x000 with no idle cycle; the read returns the new data;
  - drop PENABLE mid-wait on a write to 0x00C; the write is lost, the FSM returns to IDLE, and the next transfer completes normally.
